// File: rtl/mux_scan.sv
// Registered N:1 channel multiplexer with manual select and auto-scan (per-channel dwell).
// Optional macro MUX_SCAN_BLANK_EN blanks o/onehot on the first cycle of each scan dwell.
module mux_scan #(
  parameter int CH    = 8,
  parameter int W     = 4,
  parameter int DWELL = 4,
  parameter int SELW  = $clog2(CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CH*W-1:0]   in,
  input  logic [SELW-1:0]   sel,
  input  logic              e,
  input  logic              scan,
  output logic [W-1:0]      o,
  output logic [SELW-1:0]   ch,
  output logic [CH-1:0]     onehot,
  output logic              wrap
);

  localparam int CW   = $clog2(DWELL + 1);
  localparam int NSEL = 1 << SELW;

  logic [W-1:0]    chan [NSEL];
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [SELW-1:0] ch_q, ch_d;
  logic [W-1:0]    o_q, o_d;
  logic [CH-1:0]   onehot_q, onehot_d, hit;
  logic            wrap_q, wrap_d;
  logic            blank;

  // Indices CH..2^SELW-1 read as zero, so an out-of-range select blanks o naturally.
  for (genvar gi = 0; gi < NSEL; gi++) begin : g_chan
    if (gi < CH) begin : g_live
      assign chan[gi] = in[gi*W +: W];
    end else begin : g_pad
      assign chan[gi] = '0;
    end
  end

  for (genvar gi = 0; gi < CH; gi++) begin : g_hit
    assign hit[gi] = (ch_d == SELW'(gi));
  end

`ifdef MUX_SCAN_BLANK_EN
  if (DWELL < 2) begin : g_dwell_check
    $error("mux_scan: MUX_SCAN_BLANK_EN requires DWELL >= 2");
  end
  assign blank = scan && (cnt_d == '0);
`else
  assign blank = 1'b0;
`endif

  always_comb begin
    cnt_d    = cnt_q;
    ch_d     = ch_q;
    wrap_d   = 1'b0;
    o_d      = '0;
    onehot_d = '0;
    if (e) begin
      if (scan) begin
        if (cnt_q == CW'(DWELL - 1)) begin
          cnt_d = '0;
          // Wrap explicitly at CH; a stale out-of-range ch also restarts at 0.
          if (ch_q >= SELW'(CH - 1)) begin
            ch_d   = '0;
            wrap_d = (ch_q == SELW'(CH - 1));
          end else begin
            ch_d = ch_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end else begin
        cnt_d = '0;
        ch_d  = sel;
      end
      if (!blank) begin
        o_d      = chan[ch_d];
        onehot_d = hit;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      ch_q     <= '0;
      o_q      <= '0;
      onehot_q <= '0;
      wrap_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      ch_q     <= ch_d;
      o_q      <= o_d;
      onehot_q <= onehot_d;
      wrap_q   <= wrap_d;
    end
  end

  assign o      = o_q;
  assign ch     = ch_q;
  assign onehot = onehot_q;
  assign wrap   = wrap_q;

endmodule

// File: tb/tb_mux_scan.sv
// Self-checking bench for mux_scan: directed scenarios plus randomized traffic against
// a scan-phase reference model (phase = ch*DWELL + cnt, advanced modulo CH*DWELL).
module tb_mux_scan;
  localparam int CH = 8, W = 4, DWELL = 4, SELW = 3;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [CH*W-1:0] din = '0;
  logic [SELW-1:0] sel = '0;
  logic            e = 1'b1;
  logic            scan = 1'b0;
  logic [W-1:0]    o;
  logic [SELW-1:0] ch;
  logic [CH-1:0]   onehot;
  logic            wrap;

  mux_scan #(.CH(CH), .W(W), .DWELL(DWELL)) dut (
    .clk(clk), .rst(rst), .in(din), .sel(sel), .e(e), .scan(scan),
    .o(o), .ch(ch), .onehot(onehot), .wrap(wrap)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int p = 0;
  int wraps;
  logic [W-1:0]    exp_o = '0;
  logic [SELW-1:0] exp_ch = '0;
  logic [CH-1:0]   exp_oh = '0;
  logic            exp_wrap = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: scan position as a single phase counter over all channels and dwell slots.
  task automatic model_step();
    exp_wrap = 1'b0;
    if (rst) begin
      p = 0; exp_o = '0; exp_ch = '0; exp_oh = '0;
      return;
    end
    if (!e) begin
      exp_o = '0; exp_oh = '0;
      return;
    end
    if (scan) begin
      p = (p + 1) % (CH * DWELL);
      exp_wrap = (p == 0);
    end else begin
      p = int'(sel) * DWELL;
    end
    exp_ch = SELW'(p / DWELL);
    exp_o  = W'(din >> (int'(exp_ch) * W));
    exp_oh = CH'(1) << exp_ch;
`ifdef MUX_SCAN_BLANK_EN
    if (scan && (p % DWELL == 0)) begin
      exp_o = '0; exp_oh = '0;
    end
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    $display("[TB] t=%0t rst=%b e=%b scan=%b sel=%0d o=%h ch=%0d oh=%b wrap=%b",
             $time, rst, e, scan, sel, o, ch, onehot, wrap);
    chk("o", o, exp_o);
    chk("ch", ch, exp_ch);
    chk("onehot", onehot, exp_oh);
    chk("wrap", wrap, exp_wrap);
  endtask

  task automatic run_to(input int target);
    for (int i = 0; i < 200 && p != target; i++) tick();
    chk("reach_phase", p, target);
  endtask

  initial begin
    // Power-on reset, checked before any clock edge.
    #2 rst = 1'b1;
    #1;
    chk("rst_o", o, 0);
    chk("rst_ch", ch, 0);
    chk("rst_oh", onehot, 0);
    chk("rst_wrap", wrap, 0);
    tick();
    rst = 1'b0;

    // Manual sweep: channel k carries value k.
    din = 32'h7654_3210;
    scan = 1'b0; e = 1'b1;
    for (int s = 0; s < CH; s++) begin
      sel = SELW'(s);
      tick();
      chk("man_o", o, s);
    end

    // Scan from channel 0: two full rotations give exactly two wrap pulses.
    sel = '0;
    tick();
    scan = 1'b1;
    wraps = 0;
    for (int i = 0; i < 2 * CH * DWELL; i++) begin
      tick();
      if (wrap) wraps++;
    end
    chk("wrap_count", wraps, 2);

    // Asynchronous reset mid-scan at ch=5.
    run_to(5 * DWELL + 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_o", o, 0);
    chk("arst_ch", ch, 0);
    chk("arst_oh", onehot, 0);
    chk("arst_wrap", wrap, 0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < DWELL - 1; i++) begin
      tick();
      chk("post_rst_ch0", ch, 0);
    end
    tick();
    chk("post_rst_ch1", ch, 1);

    // Enable freeze at ch=3, cnt=2.
    run_to(3 * DWELL + 2);
    e = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("frz_o", o, 0);
      chk("frz_ch", ch, 3);
    end
    e = 1'b1;
    tick();
    chk("frz_hold", ch, 3);
    tick();
    chk("frz_adv", ch, 4);

    // Mode switch: scan at ch=6 -> manual sel=2 -> scan again.
    run_to(6 * DWELL + 1);
    scan = 1'b0; sel = 3'd2;
    tick();
    chk("sw_ch", ch, 2);
    chk("sw_o", o, 2);
    scan = 1'b1;
    for (int i = 0; i < DWELL - 1; i++) begin
      tick();
      chk("sw_hold", ch, 2);
    end
    tick();
    chk("sw_adv", ch, 3);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      din  = $urandom;
      sel  = SELW'($urandom_range(0, CH - 1));
      e    = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 15) == 0) scan = ~scan;
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
